// File: rtl/fir_stream_sink_if.sv
// Downstream lane-word stream of fir_stream_sink.
// master drives the words, slave returns m_ready.
interface fir_stream_sink_if #(
  parameter int LANE_W = 32
);
  logic [LANE_W-1:0] m_data;
  logic [1:0]        m_lane;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output m_data, m_lane, m_last, m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data, m_lane, m_last, m_valid,
    output m_ready
  );
endinterface

// File: rtl/fir_stream_sink.sv
// Filter-output sink: beat FIFO + 3-lane serializer.
// Optional FIR_SINK_STATS_EN adds drop_cnt / ovf_cnt.
module fir_stream_sink #(
  parameter int DEPTH  = 4,
  parameter int LANE_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3*LANE_W-1:0]   ast_sink_data,
  input  logic                  ast_sink_valid,
  input  logic [1:0]            ast_sink_error,
  fir_stream_sink_if.master     dn,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                  ovf_sticky
`ifdef FIR_SINK_STATS_EN
  ,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    L0,
    L1,
    L2
  } state_t;

  state_t state, state_nxt;

  logic [3*LANE_W-1:0] mem [DEPTH];
  logic [3*LANE_W-1:0] hold;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;

  logic push;
  logic bad;
  logic avail;
  logic load;
  logic accept;
  logic ovf;

  assign push   = ast_sink_valid && (ast_sink_error == 2'b00);
  assign bad    = ast_sink_valid && (ast_sink_error != 2'b00);
  assign avail  = (fifo_level != '0);
  // a load frees a slot, so a full FIFO can still take a beat
  assign accept = push && ((fifo_level < FULL) || load);
  assign ovf    = push && !accept;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (avail) begin
          load      = 1'b1;
          state_nxt = L0;
        end
      end
      L0: if (dn.m_ready) state_nxt = L1;
      L1: if (dn.m_ready) state_nxt = L2;
      L2: begin
        if (dn.m_ready) begin
          if (avail) begin
            load      = 1'b1;
            state_nxt = L0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= ast_sink_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      hold       <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold   <= mem[rd_ptr];
      end
      unique case ({accept, load})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (ovf) ovf_sticky <= 1'b1;
    end
  end

`ifdef FIR_SINK_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (bad && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      if (ovf && ovf_cnt != 16'hFFFF)  ovf_cnt  <= ovf_cnt + 1'b1;
    end
  end
`else
  logic unused_bad;
  assign unused_bad = bad;
`endif

  always_comb begin
    dn.m_valid = (state != IDLE);
    dn.m_last  = (state == L2);
    dn.m_lane  = 2'd0;
    dn.m_data  = hold[0 +: LANE_W];
    unique case (1'b1)
      (state == L1): begin
        dn.m_lane = 2'd1;
        dn.m_data = hold[LANE_W +: LANE_W];
      end
      (state == L2): begin
        dn.m_lane = 2'd2;
        dn.m_data = hold[2*LANE_W +: LANE_W];
      end
      default: begin
        dn.m_lane = 2'd0;
        dn.m_data = hold[0 +: LANE_W];
      end
    endcase
  end

endmodule
